// File: rtl/mproc_pkg.sv
// Shared encodings and instruction field positions for the mproc multi-cycle control core.
package mproc_pkg;

   localparam logic [1:0] CLS_ALU  = 2'b00;
   localparam logic [1:0] CLS_JMP  = 2'b01;
   localparam logic [1:0] CLS_BZ   = 2'b10;
   localparam logic [1:0] CLS_HALT = 2'b11;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StFetch = 2'b01,
      StExec  = 2'b10,
      StHalt  = 2'b11
   } state_e;

   // Fields are packed MSB first: cls, op, wr, a, b.
   function automatic int unsigned cls_lsb(int unsigned dw);
      return dw - 2;
   endfunction

   function automatic int unsigned op_lsb(int unsigned dw);
      return dw - 4;
   endfunction

   function automatic int unsigned wr_lsb(int unsigned dw, int unsigned raw);
      return dw - 4 - raw;
   endfunction

   function automatic int unsigned a_lsb(int unsigned dw, int unsigned raw);
      return dw - 4 - 2 * raw;
   endfunction

   function automatic int unsigned b_lsb(int unsigned dw, int unsigned raw);
      return dw - 4 - 3 * raw;
   endfunction

endpackage

// File: rtl/mproc_pc.sv
// Program counter: AW-bit register that wraps modulo 2^AW; load has priority over inc.
module mproc_pc #(
   parameter int unsigned AW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          load,
   input  logic [AW-1:0] target,
   output logic [AW-1:0] pc
);

   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = target;
      end else if (inc) begin
         pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/mproc_mc.sv
// Multi-cycle control core: fetch/execute FSM with memory handshake, instruction register,
// decode to the reg_alu datapath, conditional branch and halt.
module mproc_mc
   import mproc_pkg::*;
#(
   parameter int unsigned DW  = 16,
   parameter int unsigned AW  = 7,
   parameter int unsigned RAW = 3
) (
   input  logic           clk,
   input  logic           reset,
   output logic           mem_req,
   input  logic           mem_ack,
   output logic [AW-1:0]  addr,
   input  logic [DW-1:0]  d_in,
   input  logic           zero,
   output logic [RAW-1:0] rd_addr_a,
   output logic [RAW-1:0] rd_addr_b,
   output logic [RAW-1:0] wr_addr,
   output logic [1:0]     op,
   output logic           wr_reg,
   output logic           halted
);

   localparam int unsigned ClsLsb = cls_lsb(DW);
   localparam int unsigned OpLsb  = op_lsb(DW);
   localparam int unsigned WrLsb  = wr_lsb(DW, RAW);
   localparam int unsigned ALsb   = a_lsb(DW, RAW);
   localparam int unsigned BLsb   = b_lsb(DW, RAW);

   state_e        state_q;
   logic [DW-1:0] ir_q;
   logic          mem_req_q;
   logic          wr_reg_q;
   logic          halted_q;
   logic [1:0]    cls;
   logic [1:0]    d_in_cls;
   logic          pc_inc;
   logic          pc_load;
   logic [AW-1:0] pc;

   assign cls      = ir_q[ClsLsb +: 2];
   assign d_in_cls = d_in[ClsLsb +: 2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q <= '0;
      end else if (state_q == StFetch && mem_ack) begin
         ir_q <= d_in;
      end
   end

   always_comb begin
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      if (state_q == StExec) begin
         case (cls)
            CLS_ALU: pc_inc = 1'b1;
            CLS_JMP: pc_load = 1'b1;
            CLS_BZ: begin
               pc_load = zero;
               pc_inc  = !zero;
            end
            default: ;
         endcase
      end
   end

   mproc_pc #(
      .AW(AW)
   ) u_pc (
      .clk   (clk),
      .reset (reset),
      .inc   (pc_inc),
      .load  (pc_load),
      .target(ir_q[AW-1:0]),
      .pc    (pc)
   );

   // wr_reg is decided from d_in at the fetch edge so the pulse lines up with EXEC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         mem_req_q <= 1'b0;
         wr_reg_q  <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               state_q   <= StFetch;
               mem_req_q <= 1'b1;
            end
            StFetch: begin
               if (mem_ack) begin
                  state_q   <= StExec;
                  mem_req_q <= 1'b0;
                  wr_reg_q  <= (d_in_cls == CLS_ALU);
               end
            end
            StExec: begin
               wr_reg_q <= 1'b0;
               if (cls == CLS_HALT) begin
                  state_q  <= StHalt;
                  halted_q <= 1'b1;
               end else begin
                  state_q   <= StFetch;
                  mem_req_q <= 1'b1;
               end
            end
            StHalt: begin
               mem_req_q <= 1'b0;
               halted_q  <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign wr_reg    = wr_reg_q;
   assign halted    = halted_q;
   assign addr      = pc;
   assign op        = ir_q[OpLsb +: 2];
   assign wr_addr   = ir_q[WrLsb +: RAW];
   assign rd_addr_a = ir_q[ALsb +: RAW];
   assign rd_addr_b = ir_q[BLsb +: RAW];

endmodule

// File: tb/tb_mproc_mc.sv
// Self-checking bench for mproc_mc: default and wide parameter sets against an ISA-level model.
module tb_mproc_mc;

   logic        clk;
   logic        rst1;
   logic        rst2;
   logic        mem_ack;
   logic [23:0] d_in;
   logic        zero;
   bit          sel;

   logic       m1_mem_req, m1_wr_reg, m1_halted;
   logic [6:0] m1_addr;
   logic [2:0] m1_rd_a, m1_rd_b, m1_wr_addr;
   logic [1:0] m1_op;

   logic       m2_mem_req, m2_wr_reg, m2_halted;
   logic [9:0] m2_addr;
   logic [3:0] m2_rd_a, m2_rd_b, m2_wr_addr;
   logic [1:0] m2_op;

   logic       o_mem_req, o_wr_reg, o_halted;
   logic [9:0] o_addr;
   logic [3:0] o_rd_a, o_rd_b, o_wr_addr;
   logic [1:0] o_op;

   int errors = 0;
   int checks = 0;
   int pc_model = 0;
   int dw = 16;
   int aw = 7;
   int raw = 3;

   mproc_mc #(.DW(16), .AW(7), .RAW(3)) u_dut16 (
      .clk      (clk),
      .reset    (rst1),
      .mem_req  (m1_mem_req),
      .mem_ack  (mem_ack),
      .addr     (m1_addr),
      .d_in     (d_in[15:0]),
      .zero     (zero),
      .rd_addr_a(m1_rd_a),
      .rd_addr_b(m1_rd_b),
      .wr_addr  (m1_wr_addr),
      .op       (m1_op),
      .wr_reg   (m1_wr_reg),
      .halted   (m1_halted)
   );

   mproc_mc #(.DW(24), .AW(10), .RAW(4)) u_dut24 (
      .clk      (clk),
      .reset    (rst2),
      .mem_req  (m2_mem_req),
      .mem_ack  (mem_ack),
      .addr     (m2_addr),
      .d_in     (d_in),
      .zero     (zero),
      .rd_addr_a(m2_rd_a),
      .rd_addr_b(m2_rd_b),
      .wr_addr  (m2_wr_addr),
      .op       (m2_op),
      .wr_reg   (m2_wr_reg),
      .halted   (m2_halted)
   );

   always_comb begin
      if (sel) begin
         o_mem_req = m2_mem_req; o_wr_reg = m2_wr_reg; o_halted = m2_halted;
         o_addr = m2_addr; o_rd_a = m2_rd_a; o_rd_b = m2_rd_b;
         o_wr_addr = m2_wr_addr; o_op = m2_op;
      end else begin
         o_mem_req = m1_mem_req; o_wr_reg = m1_wr_reg; o_halted = m1_halted;
         o_addr = {3'b000, m1_addr}; o_rd_a = {1'b0, m1_rd_a}; o_rd_b = {1'b0, m1_rd_b};
         o_wr_addr = {1'b0, m1_wr_addr}; o_op = m1_op;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int fld(input int v, input int lsb, input int w);
      return (v >> lsb) & ((1 << w) - 1);
   endfunction

   function automatic int make_instr(input int c, input int rest);
      return (c << (dw - 2)) | (rest & ((1 << (dw - 2)) - 1));
   endfunction

   task automatic test_reset();
      @(negedge clk);
      rst1 = 1'b0; rst2 = 1'b0; mem_ack = 1'b0; zero = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_mem_req, o_addr, o_wr_reg, o_halted, o_rd_a, o_rd_b, o_wr_addr, o_op} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: mem_req=%0b addr=%0h wr_reg=%0b halted=%0b rd_a=%0h rd_b=%0h wr=%0h op=%0h, want all 0",
                  o_mem_req, o_addr, o_wr_reg, o_halted, o_rd_a, o_rd_b, o_wr_addr, o_op);
      end
      if (sel) rst2 = 1'b1; else rst1 = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (o_mem_req !== 1'b1 || o_addr !== 10'd0 || o_wr_reg !== 1'b0) begin
         errors++;
         $display("FAIL first_fetch: mem_req=%0b addr=%0h wr_reg=%0b, want 1 0 0",
                  o_mem_req, o_addr, o_wr_reg);
      end
      pc_model = 0;
   endtask

   // Precondition: at a negedge with the core in FETCH at pc_model.
   task automatic run_instr(input int instr_in, input int delay, input bit z);
      int instr, c, nxt, mask;
      mask  = (1 << aw) - 1;
      instr = instr_in & ((1 << dw) - 1);
      c     = fld(instr, dw - 2, 2);
      for (int i = 0; i <= delay; i++) begin
         checks++;
         if (o_mem_req !== 1'b1 || o_wr_reg !== 1'b0 || o_halted !== 1'b0 || o_addr !== pc_model) begin
            errors++;
            $display("FAIL fetch_hold: mem_req=%0b wr_reg=%0b halted=%0b addr=%0h, want 1 0 0 %0h",
                     o_mem_req, o_wr_reg, o_halted, o_addr, pc_model);
         end
         if (i == delay) begin
            mem_ack = 1'b1; d_in = 24'(instr);
         end else begin
            mem_ack = 1'b0; d_in = 24'($urandom);
         end
         @(negedge clk);
      end
      zero = z; mem_ack = 1'($urandom); d_in = 24'($urandom);
      checks++;
      if (o_mem_req !== 1'b0 || o_halted !== 1'b0 || o_addr !== pc_model || o_wr_reg !== (c == 0)) begin
         errors++;
         $display("FAIL exec_ctrl: mem_req=%0b halted=%0b addr=%0h wr_reg=%0b, want 0 0 %0h %0b",
                  o_mem_req, o_halted, o_addr, o_wr_reg, pc_model, (c == 0));
      end
      checks++;
      if (o_op !== fld(instr, dw - 4, 2) || o_wr_addr !== fld(instr, dw - 4 - raw, raw) ||
          o_rd_a !== fld(instr, dw - 4 - 2 * raw, raw) || o_rd_b !== fld(instr, dw - 4 - 3 * raw, raw)) begin
         errors++;
         $display("FAIL exec_decode: instr=%0h op=%0h wr=%0h a=%0h b=%0h, want %0h %0h %0h %0h",
                  instr, o_op, o_wr_addr, o_rd_a, o_rd_b, fld(instr, dw - 4, 2),
                  fld(instr, dw - 4 - raw, raw), fld(instr, dw - 4 - 2 * raw, raw),
                  fld(instr, dw - 4 - 3 * raw, raw));
      end
      @(negedge clk);
      mem_ack = 1'b0;
      case (c)
         0: nxt = (pc_model + 1) & mask;
         1: nxt = instr & mask;
         2: nxt = z ? (instr & mask) : ((pc_model + 1) & mask);
         default: nxt = pc_model;
      endcase
      checks++;
      if (c == 3) begin
         if (o_mem_req !== 1'b0 || o_halted !== 1'b1 || o_addr !== nxt || o_wr_reg !== 1'b0) begin
            errors++;
            $display("FAIL enter_halt: mem_req=%0b halted=%0b addr=%0h wr_reg=%0b, want 0 1 %0h 0",
                     o_mem_req, o_halted, o_addr, o_wr_reg, nxt);
         end
      end else if (o_mem_req !== 1'b1 || o_halted !== 1'b0 || o_addr !== nxt || o_wr_reg !== 1'b0) begin
         errors++;
         $display("FAIL next_pc: mem_req=%0b halted=%0b addr=%0h wr_reg=%0b, want 1 0 %0h 0",
                  o_mem_req, o_halted, o_addr, o_wr_reg, nxt);
      end
      pc_model = nxt;
   endtask

   task automatic test_back_to_back();
      test_reset();
      for (int i = 0; i < 6; i++) run_instr(0, 0, 1'b0);
   endtask

   task automatic test_ack_wait();
      test_reset();
      for (int i = 0; i < 5; i++) run_instr(make_instr(0, $urandom), 0, 1'b0);
      run_instr(make_instr(0, $urandom), 3, 1'b0);
   endtask

   task automatic test_jmp_wrap();
      run_instr(make_instr(1, (1 << aw) - 1), 0, 1'b0);
      run_instr(make_instr(0, $urandom), 0, 1'b0);
      checks++;
      if (o_addr !== 10'd0) begin
         errors++;
         $display("FAIL pc_wrap: addr=%0h, want 0", o_addr);
      end
   endtask

   task automatic test_bz();
      int bz;
      bz = (2 << (dw - 2)) | (2 << (dw - 4 - 2 * raw)) | 'h20;
      run_instr(bz, 0, 1'b1);
      checks++;
      if (o_addr !== 10'h20) begin
         errors++;
         $display("FAIL bz_taken: addr=%0h, want 20", o_addr);
      end
      run_instr(bz, 1, 1'b0);
      checks++;
      if (o_addr !== 10'h21) begin
         errors++;
         $display("FAIL bz_not_taken: addr=%0h, want 21", o_addr);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         run_instr(make_instr($urandom_range(0, 2), $urandom), $urandom_range(0, 2),
                   1'($urandom));
      end
   endtask

   task automatic test_halt();
      test_reset();
      for (int i = 0; i < 3; i++) run_instr(make_instr(0, $urandom), 0, 1'b0);
      run_instr(make_instr(3, $urandom), 0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         mem_ack = 1'($urandom); d_in = 24'($urandom);
         @(negedge clk);
         checks++;
         if (o_halted !== 1'b1 || o_mem_req !== 1'b0 || o_addr !== 10'd3 || o_wr_reg !== 1'b0) begin
            errors++;
            $display("FAIL halt_stuck: halted=%0b mem_req=%0b addr=%0h wr_reg=%0b, want 1 0 3 0",
                     o_halted, o_mem_req, o_addr, o_wr_reg);
         end
      end
      test_reset();
   endtask

   task automatic test_reset_exec();
      test_reset();
      run_instr(make_instr(0, $urandom), 0, 1'b0);
      mem_ack = 1'b1; d_in = 24'(make_instr(0, $urandom | 1));
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (o_wr_reg !== 1'b1) begin
         errors++;
         $display("FAIL exec_before_abort: wr_reg=%0b, want 1", o_wr_reg);
      end
      if (sel) rst2 = 1'b0; else rst1 = 1'b0;
      #1;
      checks++;
      if ({o_mem_req, o_addr, o_wr_reg, o_halted, o_rd_a, o_rd_b, o_wr_addr, o_op} !== '0) begin
         errors++;
         $display("FAIL async_abort: mem_req=%0b addr=%0h wr_reg=%0b halted=%0b rd_a=%0h rd_b=%0h wr=%0h op=%0h, want all 0",
                  o_mem_req, o_addr, o_wr_reg, o_halted, o_rd_a, o_rd_b, o_wr_addr, o_op);
      end
      test_reset();
      run_instr(make_instr(0, $urandom), 0, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      rst1 = 1'b0; rst2 = 1'b0; mem_ack = 1'b0; d_in = '0; zero = 1'b0; sel = 1'b0;
      dw = 16; aw = 7; raw = 3;
      test_back_to_back();
      test_ack_wait();
      test_jmp_wrap();
      test_bz();
      test_random();
      test_halt();
      test_reset_exec();

      sel = 1'b1; dw = 24; aw = 10; raw = 4;
      test_back_to_back();
      test_ack_wait();
      test_jmp_wrap();
      test_bz();
      test_random();
      test_halt();
      test_reset_exec();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
